// File: rtl/rca_pkg.sv
// Shared definitions for the 8-bit ripple-carry add/sub response checker.
//  - W         : adder operand width (result z is W+1 bits)
//  - state_t   : checker run-control states
//  - rca_golden: reference add/sub returning {exp_c, exp_z}
package rca_pkg;

   localparam int W = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Reference result of the add/sub unit. Subtraction wraps modulo
   // 2**(W+1); its carry is that of a + ~b + 1, i.e. "no borrow" (a >= b).
   function automatic logic [W+1:0] rca_golden(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic         sub
   );
      logic [W:0] ext_a_s;
      logic [W:0] ext_b_s;
      logic [W:0] exp_z_s;
      logic       exp_c_s;
      ext_a_s = {1'b0, a};
      ext_b_s = {1'b0, b};
      if (sub) begin
         exp_z_s = ext_a_s - ext_b_s;
         exp_c_s = (a >= b);
      end else begin
         exp_z_s = ext_a_s + ext_b_s;
         exp_c_s = exp_z_s[W];
      end
      return {exp_c_s, exp_z_s};
   endfunction

endpackage

// File: rtl/rca8_golden.sv
// Combinational golden model of the add/sub unit.
// Ports:
//  a, b   in  W     operands
//  sub    in  1     0 = add, 1 = subtract
//  exp_z  out W+1   expected result
//  exp_c  out 1     expected carry-out
module rca8_golden
   import rca_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W:0]   exp_z,
   output logic         exp_c
);

   logic [W+1:0] gold_s;

   assign gold_s = rca_golden(a, b, sub);
   assign exp_z  = gold_s[W:0];
   assign exp_c  = gold_s[W+1];

endmodule

// File: rtl/rca8_resp_checker.sv
// On-chip response checker for the 8-bit ripple-carry add/sub unit.
// Each accepted vector {a, b, sub, z, cout} is registered into a single
// compare stage; one cycle later the golden result is compared and the
// error counter / first-fail capture are updated.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  start        begins a run (honoured in IDLE or DONE)
//  in_valid     vector valid; in_ready high only while running
//  a, b, sub    stimulus applied to the adder
//  z, cout      adder response under test
//  busy, done   run in progress / run complete (held until next start)
//  pass         with done: no mismatches this run
//  vec_cnt      vectors accepted this run
//  err_cnt      mismatching vectors (saturating)
//  fail_idx     index of the first failing vector
//  fail_vec     {a, b, sub} of the first failing vector
module rca8_resp_checker
   import rca_pkg::*;
#(
   parameter int NVEC = 64,
   parameter int CNTW = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic            sub,
   input  logic [W:0]      z,
   input  logic            cout,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [CNTW-1:0] vec_cnt,
   output logic [CNTW-1:0] err_cnt,
   output logic [CNTW-1:0] fail_idx,
   output logic [2*W:0]    fail_vec
);

   localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NVEC - 1);
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

   state_t          state_r;
   state_t          state_nxt_s;

   logic            s1_valid_r;
   logic [W-1:0]    s1_a_r;
   logic [W-1:0]    s1_b_r;
   logic            s1_sub_r;
   logic [W:0]      s1_z_r;
   logic            s1_cout_r;
   logic [CNTW-1:0] s1_idx_r;

   logic [W:0]      gold_z_s;
   logic            gold_c_s;

   logic            accept_s;
   logic            clear_s;
   logic            mismatch_s;
   logic            first_fail_s;
   logic [CNTW-1:0] err_nxt_s;

   rca8_golden u_golden (
      .a     (s1_a_r),
      .b     (s1_b_r),
      .sub   (s1_sub_r),
      .exp_z (gold_z_s),
      .exp_c (gold_c_s)
   );

   // Handshake, run-clear and compare decode.
   always_comb begin
      accept_s     = in_valid && in_ready;
      // start is only honoured outside a run; in DONE it overrides in_valid
      // because in_ready is already low there.
      clear_s      = start && ((state_r == S_IDLE) || (state_r == S_DONE));
      mismatch_s   = s1_valid_r && ((s1_z_r != gold_z_s) || (s1_cout_r != gold_c_s));
      first_fail_s = mismatch_s && (err_cnt == CNT_ZERO);
      if (clear_s) begin
         err_nxt_s = CNT_ZERO;
      end else if (mismatch_s && (err_cnt != CNT_MAX)) begin
         err_nxt_s = err_cnt + CNT_ONE;
      end else begin
         err_nxt_s = err_cnt;
      end
   end

   // Run-control next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = S_RUN;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (accept_s && (vec_cnt == LAST_IDX)) begin
               state_nxt_s = S_DRAIN;
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         // The last vector is compared during this single cycle.
         S_DRAIN: begin
            state_nxt_s = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               state_nxt_s = S_RUN;
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Registered status outputs, decoded from the upcoming state so they
   // line up with state_r. pass sees the final compare via err_nxt_s.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
      end else begin
         in_ready <= (state_nxt_s == S_RUN);
         busy     <= (state_nxt_s == S_RUN) || (state_nxt_s == S_DRAIN);
         done     <= (state_nxt_s == S_DONE);
         pass     <= (state_nxt_s == S_DONE) && (err_nxt_s == CNT_ZERO);
      end
   end

   // Compare stage: captures the accepted vector; valid drops on a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= {W{1'b0}};
         s1_b_r     <= {W{1'b0}};
         s1_sub_r   <= 1'b0;
         s1_z_r     <= {(W+1){1'b0}};
         s1_cout_r  <= 1'b0;
         s1_idx_r   <= CNT_ZERO;
      end else begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_a_r    <= a;
            s1_b_r    <= b;
            s1_sub_r  <= sub;
            s1_z_r    <= z;
            s1_cout_r <= cout;
            s1_idx_r  <= vec_cnt;
         end
      end
   end

   // Vector and error counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt <= CNT_ZERO;
         err_cnt <= CNT_ZERO;
      end else begin
         err_cnt <= err_nxt_s;
         if (clear_s) begin
            vec_cnt <= CNT_ZERO;
         end else if (accept_s) begin
            vec_cnt <= vec_cnt + CNT_ONE;
         end
      end
   end

   // First-fail capture: written only while no earlier error is recorded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_idx <= CNT_ZERO;
         fail_vec <= {(2*W+1){1'b0}};
      end else begin
         if (clear_s) begin
            fail_idx <= CNT_ZERO;
            fail_vec <= {(2*W+1){1'b0}};
         end else if (first_fail_s) begin
            fail_idx <= s1_idx_r;
            fail_vec <= {s1_a_r, s1_b_r, s1_sub_r};
         end
      end
   end

endmodule

// File: tb/tb_rca8_resp_checker.sv
// Directed self-checking bench for rca8_resp_checker.
module tb_rca8_resp_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a = 8'd0;
   logic [7:0]  b = 8'd0;
   logic        sub = 1'b0;
   logic [8:0]  z = 9'd0;
   logic        cout = 1'b0;
   logic        busy;
   logic        done;
   logic        pass;
   logic [6:0]  vec_cnt;
   logic [6:0]  err_cnt;
   logic [6:0]  fail_idx;
   logic [16:0] fail_vec;

   int total = 0;
   int bad = 0;

   rca8_resp_checker dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .z        (z),
      .cout     (cout),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .vec_cnt  (vec_cnt),
      .err_cnt  (err_cnt),
      .fail_idx (fail_idx),
      .fail_vec (fail_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Bench-side reference: integer arithmetic, masked to 9 bits.
   function automatic logic [9:0] ref_model(input logic [7:0] va, input logic [7:0] vb, input logic vs);
      int         r;
      logic       c;
      logic [8:0] zz;
      if (vs) begin
         r = int'(va) - int'(vb);
         c = (va >= vb);
      end else begin
         r = int'(va) + int'(vb);
         c = (r > 255);
      end
      zz = r[8:0];
      return {c, zz};
   endfunction

   // Called just after a negedge; returns just after the negedge that
   // follows the accepting posedge.
   task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                       input logic [8:0] vz, input logic vc);
      int n;
      a = va; b = vb; sub = vs; z = vz; cout = vc;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("ready_wait", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic start_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int cyc;
      cyc = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask

   // 64-vector sweep a=2k, b=k (or borrow pattern a=0,b=1); optional z
   // faults at fz1/fz2, cout fault at fc, idle cycle between vectors.
   task automatic run_vectors(input logic s, input int fz1, input int fz2, input int fc,
                              input bit stall, input bit borrow);
      logic [7:0] va;
      logic [7:0] vb;
      logic [9:0] r;
      logic [8:0] vz;
      logic       vc;
      for (int k = 0; k < 64; k++) begin
         va = borrow ? 8'd0 : 8'(2 * k);
         vb = borrow ? 8'd1 : 8'(k);
         r  = ref_model(va, vb, s);
         vz = r[8:0];
         vc = r[9];
         if (k == fz1 || k == fz2) vz = vz ^ 9'h004;
         if (k == fc) vc = ~vc;
         if (k == 10) start = 1'b1;   // must be ignored while running
         send(va, vb, s, vz, vc);
         start = 1'b0;
         if (stall && k < 63) begin
            @(negedge clk);
            if (k == 31) chk("stall_vec_cnt", 32'(vec_cnt), 32'd32);
         end
      end
   endtask

   initial begin
      logic [9:0] r;
      // Reset state
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_fail_idx", 32'(fail_idx), 32'd0);
      chk("rst_fail_vec", 32'(fail_vec), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1. Add sweep
      start_run();
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_ready", 32'(in_ready), 32'd1);
      run_vectors(1'b0, -1, -1, -1, 1'b0, 1'b0);
      wait_done();
      chk("t1_pass", 32'(pass), 32'd1);
      chk("t1_vec_cnt", 32'(vec_cnt), 32'd64);
      chk("t1_err_cnt", 32'(err_cnt), 32'd0);
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_ready_end", 32'(in_ready), 32'd0);

      // 2. Subtract sweep
      start_run();
      chk("t2_done_clr", 32'(done), 32'd0);
      chk("t2_vec_clr", 32'(vec_cnt), 32'd0);
      run_vectors(1'b1, -1, -1, -1, 1'b0, 1'b0);
      wait_done();
      chk("t2_pass", 32'(pass), 32'd1);
      chk("t2_err_cnt", 32'(err_cnt), 32'd0);

      // 3a. Borrow vector with correct response
      start_run();
      run_vectors(1'b1, -1, -1, -1, 1'b0, 1'b1);
      wait_done();
      chk("t3a_pass", 32'(pass), 32'd1);
      chk("t3a_err_cnt", 32'(err_cnt), 32'd0);

      // 3b. Borrow vector with wrong cout on vector 0
      start_run();
      send(8'h00, 8'h01, 1'b1, 9'h1FF, 1'b1);
      chk("t3b_vec_lat", 32'(vec_cnt), 32'd1);
      chk("t3b_err_lat", 32'(err_cnt), 32'd0);
      send(8'h00, 8'h01, 1'b1, 9'h1FF, 1'b0);
      chk("t3b_err_upd", 32'(err_cnt), 32'd1);
      chk("t3b_fail_idx", 32'(fail_idx), 32'd0);
      chk("t3b_fail_vec", 32'(fail_vec), 32'({8'h00, 8'h01, 1'b1}));
      for (int k = 2; k < 64; k++) begin
         send(8'h00, 8'h01, 1'b1, 9'h1FF, 1'b0);
      end
      wait_done();
      chk("t3b_pass", 32'(pass), 32'd0);
      chk("t3b_err_end", 32'(err_cnt), 32'd1);

      // 4. Injected z faults on vectors 5 and 9
      start_run();
      run_vectors(1'b0, 5, 9, -1, 1'b0, 1'b0);
      wait_done();
      chk("t4_err_cnt", 32'(err_cnt), 32'd2);
      chk("t4_fail_idx", 32'(fail_idx), 32'd5);
      chk("t4_fail_vec", 32'(fail_vec), 32'({8'd10, 8'd5, 1'b0}));
      chk("t4_pass", 32'(pass), 32'd0);

      // 4b. Fault on the final vector only
      start_run();
      run_vectors(1'b0, -1, -1, 63, 1'b0, 1'b0);
      wait_done();
      chk("t4b_err_cnt", 32'(err_cnt), 32'd1);
      chk("t4b_fail_idx", 32'(fail_idx), 32'd63);
      chk("t4b_fail_vec", 32'(fail_vec), 32'({8'd126, 8'd63, 1'b0}));
      chk("t4b_pass", 32'(pass), 32'd0);

      // 5. Stalls: done exactly one cycle after the last accept
      start_run();
      run_vectors(1'b0, -1, -1, -1, 1'b1, 1'b0);
      chk("t5_done_early", 32'(done), 32'd0);
      chk("t5_busy_drain", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_vec_cnt", 32'(vec_cnt), 32'd64);
      chk("t5_pass", 32'(pass), 32'd1);

      // start together with in_valid in DONE: start wins
      r = ref_model(8'd1, 8'd1, 1'b0);
      a = 8'd1; b = 8'd1; sub = 1'b0; z = r[8:0]; cout = r[9];
      start = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      chk("col_vec_cnt", 32'(vec_cnt), 32'd0);
      chk("col_busy", 32'(busy), 32'd1);
      chk("col_done", 32'(done), 32'd0);

      // 6. Reset mid-run at vec_cnt=20
      for (int k = 0; k < 20; k++) begin
         r = ref_model(8'(3 * k), 8'(k + 7), 1'b1);
         send(8'(3 * k), 8'(k + 7), 1'b1, r[8:0], r[9]);
      end
      chk("t6_vec20", 32'(vec_cnt), 32'd20);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_ready", 32'(in_ready), 32'd0);
      chk("t6_rst_vec", 32'(vec_cnt), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_run();
      run_vectors(1'b0, -1, -1, -1, 1'b0, 1'b0);
      wait_done();
      chk("t6_pass", 32'(pass), 32'd1);
      chk("t6_vec_cnt", 32'(vec_cnt), 32'd64);
      chk("t6_err_cnt", 32'(err_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
